spmv_val_fetch: RTL and testbench

- Per-kernel AXI4 read master that fetches the nonzero-value (Val) array of one SpMV job from HBM and delivers it as a 256-bit stream to the kernel's multiply stage.
- Sits directly upstream of the Val crossbar slave port of each kernel; its AR/R channels drive one crossbar slave slot.
- Job parameters come from the kernel's config registers: base, beat count, start.
- Credit-based: never has more data requested than its internal FIFO can absorb, so rready stays high.

---
 rtl/spmv_val_fetch.sv | 155 +++++++++++++++
 tb/tb_spmv_val_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spmv_val_fetch.sv
// rtl/spmv_val_fetch.sv - credit-based AXI4 read master streaming one SpMV job's Val array.
// Define SPMV_VAL_FETCH_PERF_EN to add the perf_stall_cycles output and its counter.
`timescale 1ns/1ps
module spmv_val_fetch #(
  parameter int ADDR_W     = 48,
  parameter int DATA_W     = 256,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       num_beats,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [1:0]        m_axi_arburst,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rlast,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast
`ifdef SPMV_VAL_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cycles
`endif
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_next;

  logic [ADDR_W-1:0] addr;
  logic [31:0]       remaining, total, stream_cnt;
  logic [CNT_W-1:0]  outstanding, occupancy;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];

  logic [8:0] to_4k, cap, burst_len;
  logic       start_ok, ar_fire, r_fire, t_fire, credit_ok;

  assign start_ok = (state == IDLE) && start;

  // Beats left before the next 4 KB page (1..128).
  assign to_4k = 9'd128 - {2'b00, addr[11:5]};

  always_comb begin
    cap       = (to_4k < 9'(MAX_BURST)) ? to_4k : 9'(MAX_BURST);
    burst_len = (remaining < {23'd0, cap}) ? remaining[8:0] : cap;
  end

  // Occupancy plus outstanding only shrinks while a request waits, so arvalid never retracts.
  assign credit_ok = (32'(occupancy) + 32'(outstanding) + 32'(burst_len)) <= 32'(FIFO_DEPTH);

  assign busy          = (state == ISSUE) || (state == DRAIN);
  assign done          = (state == DONE);
  assign m_axi_arvalid = (state == ISSUE) && (remaining != 32'd0) && credit_ok;
  assign m_axi_araddr  = addr;
  assign m_axi_arlen   = ((state == ISSUE) && (remaining != 32'd0)) ? 8'(burst_len - 9'd1) : 8'd0;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arsize  = 3'b101;
  assign m_axi_rready  = busy;
  assign m_axis_tvalid = (occupancy != '0);
  assign m_axis_tdata  = mem[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid && (stream_cnt == total - 32'd1);

  assign ar_fire = m_axi_arvalid && m_axi_arready;
  assign r_fire  = m_axi_rvalid && m_axi_rready;
  assign t_fire  = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = (num_beats == 32'd0) ? DONE : ISSUE;
      ISSUE: if (ar_fire && (remaining == 32'(burst_len))) state_next = DRAIN;
      DRAIN: if (t_fire && m_axis_tlast) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      total       <= '0;
      stream_cnt  <= '0;
      outstanding <= '0;
      occupancy   <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      err         <= 1'b0;
    end else begin
      state <= state_next;
      if (start_ok) begin
        addr        <= base_addr;
        remaining   <= num_beats;
        total       <= num_beats;
        stream_cnt  <= '0;
        outstanding <= '0;
        occupancy   <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        err         <= 1'b0;
      end else begin
        if (ar_fire) begin
          addr      <= addr + ADDR_W'({burst_len, 5'b00000});
          remaining <= remaining - 32'(burst_len);
        end
        outstanding <= outstanding + (ar_fire ? CNT_W'(burst_len) : CNT_W'(0)) - CNT_W'(r_fire);
        occupancy   <= occupancy + CNT_W'(r_fire) - CNT_W'(t_fire);
        if (r_fire) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
          if (m_axi_rresp != 2'b00) err <= 1'b1;
        end
        if (t_fire) begin
          rd_ptr     <= rd_ptr + PTR_W'(1);
          stream_cnt <= stream_cnt + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (r_fire) mem[wr_ptr] <= m_axi_rdata;
  end

`ifdef SPMV_VAL_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) perf_stall_cycles <= '0;
    else if (start_ok) perf_stall_cycles <= '0;
    else if (busy && (occupancy == '0) && (perf_stall_cycles != 32'hFFFF_FFFF))
      perf_stall_cycles <= perf_stall_cycles + 32'd1;
  end
`endif

`ifndef SYNTHESIS
  // A beat without rlast means its burst still owes at least one more beat.
  always_ff @(posedge clk) begin
    if (rstn && r_fire && !m_axi_rlast) assert (outstanding > CNT_W'(1));
  end
`endif
endmodule

// File: tb/tb_spmv_val_fetch.sv
// tb/tb_spmv_val_fetch.sv - self-checking bench for spmv_val_fetch with AXI slave and stream models.
`timescale 1ns/1ps
module tb_spmv_val_fetch;
  logic         clk = 1'b0;
  logic         rstn, start, busy, done, err;
  logic [47:0]  base_addr, m_axi_araddr;
  logic [31:0]  num_beats;
  logic [1:0]   m_axi_arburst, m_axi_rresp;
  logic [7:0]   m_axi_arlen;
  logic [2:0]   m_axi_arsize;
  logic         m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [255:0] m_axi_rdata, m_axis_tdata;
  logic         m_axis_tvalid, m_axis_tready, m_axis_tlast;
`ifdef SPMV_VAL_FETCH_PERF_EN
  logic [31:0]  perf_stall_cycles;
`endif

  spmv_val_fetch dut (
    .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .num_beats(num_beats),
    .busy(busy), .done(done), .err(err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arburst(m_axi_arburst), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rlast(m_axi_rlast), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
`ifdef SPMV_VAL_FETCH_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [47:0] addr; int len; } ar_t;
  typedef struct { logic [47:0] addr; bit last; } rbeat_t;
  typedef struct {
    logic [47:0] base; int n; int trm; int arm; int rvm; int err_beat; int exp_ars; bit exp_err;
  } vec_t;

  ar_t    ar_log[$];
  ar_t    exp_ars[$];
  rbeat_t rq[$];
  int n_checks = 0, n_fail = 0, cyc = 0;
  int ar_mode = 1, rv_mode = 1, tr_mode = 1, err_beat = -1;
  int r_cnt, req_beats, pop_cnt, max_inflight, post_reset_r;
  int first_r_cyc, first_t_cyc, last_fire_cyc, done_cyc, done_cnt, job_n;
  logic [47:0] job_base;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] beat_data(input logic [47:0] a);
    logic [31:0] w;
    w = a[31:0];
    return {w ^ 32'hDEADBEEF, w, w * 32'h9E3779B1, ~w, w + 32'h1234, w ^ 32'h5A5A5A5A, w * 32'd3, w};
  endfunction

  function automatic bit pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(0, 3) != 0);
  endfunction

  // Reference burst split: min(16, remaining, beats to next 4 KB page), plain arithmetic.
  task automatic build_expected(input logic [47:0] base, input int n);
    longint a;
    int rem, room, len;
    a = longint'(base);
    rem = n;
    exp_ars.delete();
    while (rem > 0) begin
      room = (4096 - int'(a % 4096)) / 32;
      len = rem;
      if (len > 16) len = 16;
      if (len > room) len = room;
      exp_ars.push_back('{48'(a), len});
      a = a + longint'(len * 32);
      rem = rem - len;
    end
  endtask

  // Slave, sink and scoreboard: inputs are changed at negedge, then the handshakes
  // that the next posedge will perform are recorded.
  always @(negedge clk) begin
    if (rq.size() > 0 && pick(rv_mode)) begin
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = beat_data(rq[0].addr);
      m_axi_rlast  = rq[0].last;
      m_axi_rresp  = (r_cnt == err_beat) ? 2'b10 : 2'b00;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rdata  = '0;
      m_axi_rlast  = 1'b0;
      m_axi_rresp  = 2'b00;
    end
    m_axi_arready = pick(ar_mode);
    m_axis_tready = pick(tr_mode);
    if (m_axi_rvalid && m_axi_rready) begin
      void'(rq.pop_front());
      if (first_r_cyc < 0) first_r_cyc = cyc;
      r_cnt++;
      post_reset_r++;
    end
    if (m_axi_arvalid && m_axi_arready) begin
      ar_log.push_back('{m_axi_araddr, int'(m_axi_arlen) + 1});
      for (int i = 0; i <= int'(m_axi_arlen); i++)
        rq.push_back('{m_axi_araddr + 48'(i * 32), (i == int'(m_axi_arlen))});
      req_beats += int'(m_axi_arlen) + 1;
      if (req_beats - pop_cnt > max_inflight) max_inflight = req_beats - pop_cnt;
    end
    if (m_axis_tvalid && first_t_cyc < 0) first_t_cyc = cyc;
    if (m_axis_tvalid && m_axis_tready) begin
      check("tdata", m_axis_tdata, beat_data(job_base + 48'(pop_cnt * 32)));
      check("tlast", m_axis_tlast, (pop_cnt == job_n - 1));
      if (m_axis_tlast) last_fire_cyc = cyc;
      pop_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic clear_job(input logic [47:0] base, input int n);
    job_base = base; job_n = n; r_cnt = 0; req_beats = 0; pop_cnt = 0; max_inflight = 0;
    first_r_cyc = -1; first_t_cyc = -1; last_fire_cyc = -1; done_cyc = -1; done_cnt = 0;
    ar_log.delete();
    build_expected(base, n);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_arvalid", m_axi_arvalid, 1'b0);
    check("rst_araddr", m_axi_araddr, 48'h0);
    check("rst_arlen", m_axi_arlen, 8'h0);
    check("rst_rready", m_axi_rready, 1'b0);
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
`ifdef SPMV_VAL_FETCH_PERF_EN
    check("rst_perf", perf_stall_cycles, 32'h0);
`endif
  endtask

  task automatic start_job(input logic [47:0] base, input int n, input int trm, input int arm,
                           input int rvm, input int eb);
    @(posedge clk); #2;
    tr_mode = trm; ar_mode = arm; rv_mode = rvm; err_beat = eb;
    clear_job(base, n);
    base_addr = base; num_beats = 32'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_busy", busy, 1'b1);
    check("start_arvalid", m_axi_arvalid, 1'b1);
    check("start_arburst", m_axi_arburst, 2'b01);
    check("start_arsize", m_axi_arsize, 3'b101);
    check("start_err_clear", err, 1'b0);
  endtask

  task automatic finish_job(input bit exp_err);
    for (int k = 0; k < 20000 && done_cnt == 0; k++) @(posedge clk);
    @(posedge clk); #2;
    check("done_pulses", done_cnt, 1);
    check("beats_delivered", pop_cnt, job_n);
    check("beats_received", r_cnt, job_n);
    check("ar_count", ar_log.size(), exp_ars.size());
    for (int i = 0; i < ar_log.size() && i < exp_ars.size(); i++) begin
      check("ar_addr", ar_log[i].addr, exp_ars[i].addr);
      check("ar_len", ar_log[i].len, exp_ars[i].len);
    end
    check("done_latency", done_cyc, last_fire_cyc + 1);
    check("tvalid_latency", first_t_cyc, first_r_cyc + 1);
    check("credit_limit", (max_inflight <= 64), 1'b1);
    check("err_final", err, exp_err);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    vecs[0] = '{48'h1000,  40, 1, 1, 1, -1, 3, 1'b0};
    vecs[1] = '{48'h1F80,   8, 1, 1, 1, -1, 2, 1'b0};
    vecs[2] = '{48'h0FE0,   5, 1, 1, 1, -1, 2, 1'b0};
    vecs[3] = '{48'h2000, 100, 2, 2, 2, -1, 7, 1'b0};
    vecs[4] = '{48'h3000,  16, 1, 1, 1,  5, 1, 1'b1};
    vecs[5] = '{48'h5FC0,  70, 2, 1, 2, -1, 6, 1'b0};

    rstn = 1'b0; start = 1'b0; base_addr = '0; num_beats = '0;
    clear_job(48'h0, 0);
    post_reset_r = 0;
    repeat (3) @(posedge clk); #2;
    check_reset_outputs();
    rstn = 1'b1;

    foreach (vecs[i]) begin
      start_job(vecs[i].base, vecs[i].n, vecs[i].trm, vecs[i].arm, vecs[i].rvm, vecs[i].err_beat);
      finish_job(vecs[i].exp_err);
      check("tbl_ar_count", ar_log.size(), vecs[i].exp_ars);
    end

    // Zero-length job: straight to DONE with no traffic.
    @(posedge clk); #2;
    clear_job(48'h1000, 0);
    base_addr = 48'h1000; num_beats = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("zero_done", done, 1'b1);
    check("zero_busy", busy, 1'b0);
    check("zero_arvalid", m_axi_arvalid, 1'b0);
    @(posedge clk); #1;
    check("zero_done_pulse", done, 1'b0);
    check("zero_busy2", busy, 1'b0);
    check("zero_tvalid", m_axis_tvalid, 1'b0);
    repeat (3) @(posedge clk); #2;
    check("zero_no_ar", ar_log.size(), 0);

    // Back-pressure: credit must stop requests at 64 beats; a second start is ignored.
    start_job(48'h0, 200, 0, 1, 1, -1);
    repeat (300) @(posedge clk); #2;
    check("bp_requested", req_beats, 64);
    check("bp_arvalid", m_axi_arvalid, 1'b0);
    check("bp_tvalid", m_axis_tvalid, 1'b1);
    check("bp_popped", pop_cnt, 0);
    base_addr = 48'h9000; num_beats = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tr_mode = 2;
    finish_job(1'b0);

    // Reset mid-job: outputs clear at once and late R beats are refused.
    start_job(48'h4000, 64, 1, 1, 2, -1);
    for (int k = 0; k < 2000 && pop_cnt < 10; k++) @(posedge clk);
    #2;
    rstn = 1'b0;
    post_reset_r = 0;
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk); #2;
    rstn = 1'b1;
    repeat (4) @(posedge clk); #2;
    check("late_r_dropped", post_reset_r, 0);
    check("late_rready", m_axi_rready, 1'b0);
    check("late_beats_pending", (rq.size() > 0), 1'b1);
    rq.delete();
    start_job(48'h8000, 20, 2, 2, 2, -1);
    finish_job(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
